// File: rtl/hgame_pkg.sv
// Shared constants for the Hunch match controller: round-result codes,
// controller state encoding and player bit positions.
package hgame_pkg;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_A    = 3'b001;
  localparam logic [2:0] W_B    = 3'b010;
  localparam logic [2:0] W_C    = 3'b011;
  localparam logic [2:0] W_AB   = 3'b100;
  localparam logic [2:0] W_AC   = 3'b101;
  localparam logic [2:0] W_BC   = 3'b110;
  localparam logic [2:0] W_DRAW = 3'b111;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside every {C,B,A} player vector
  localparam int P_A = 0;
  localparam int P_B = 1;
  localparam int P_C = 2;

endpackage

// File: rtl/hgame_result_decode.sv
// Maps a WINNER_DISP code onto a {C,B,A} award vector; DRAW awards nobody
// but is still a result.
module hgame_result_decode
  import hgame_pkg::*;
(
  input  logic [2:0] i_code,
  output logic [2:0] o_award,
  output logic       o_is_result
);

  always_comb begin
    o_award     = 3'b000;
    o_is_result = (i_code != W_NONE);
    case (i_code)
      W_A:  o_award[P_A] = 1'b1;
      W_B:  o_award[P_B] = 1'b1;
      W_C:  o_award[P_C] = 1'b1;
      W_AB: begin
        o_award[P_A] = 1'b1;
        o_award[P_B] = 1'b1;
      end
      W_AC: begin
        o_award[P_A] = 1'b1;
        o_award[P_C] = 1'b1;
      end
      W_BC: begin
        o_award[P_B] = 1'b1;
        o_award[P_C] = 1'b1;
      end
      default: o_award = 3'b000;
    endcase
  end

endmodule

// File: rtl/hgame_match_ctrl.sv
// Match-level controller: scores each round result from Main_FSM, pulses the
// round reset back to it and declares the match winner(s) at WIN_TARGET.
module hgame_match_ctrl
  import hgame_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3,
  parameter int RCNT_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        WINNER_DISP,
  input  logic              NEW_MATCH,
  output logic              ROUND_RST,
  output logic [SCORE_W-1:0] SCORE_A,
  output logic [SCORE_W-1:0] SCORE_B,
  output logic [SCORE_W-1:0] SCORE_C,
  output logic [RCNT_W-1:0] ROUND_CNT,
  output logic              MATCH_DONE,
  output logic [2:0]        MATCH_WINNER
);

  localparam logic [SCORE_W-1:0] TGT = SCORE_W'(WIN_TARGET);

  state_t              r_state, w_state_nxt;
  logic [SCORE_W-1:0]  r_score_a, r_score_b, r_score_c;
  logic [SCORE_W-1:0]  w_score_a_nxt, w_score_b_nxt, w_score_c_nxt;
  logic [RCNT_W-1:0]   r_rcnt, w_rcnt_nxt;
  logic                r_round_rst, w_round_rst_nxt;
  logic                r_match_done, w_match_done_nxt;
  logic [2:0]          r_match_winner, w_match_winner_nxt;
  logic [2:0]          w_award;
  logic                w_is_result;
  logic [2:0]          w_hit;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v,
                                                   input logic inc);
    if (!inc || v >= TGT) return v;
    return v + SCORE_W'(1);
  endfunction

  function automatic logic [RCNT_W-1:0] sat_rcnt(input logic [RCNT_W-1:0] v);
    if (&v) return v;
    return v + RCNT_W'(1);
  endfunction

  hgame_result_decode u_decode (
    .i_code      (WINNER_DISP),
    .o_award     (w_award),
    .o_is_result (w_is_result)
  );

  assign w_hit[P_A] = (r_score_a == TGT);
  assign w_hit[P_B] = (r_score_b == TGT);
  assign w_hit[P_C] = (r_score_c == TGT);

  always_comb begin
    w_state_nxt        = r_state;
    w_score_a_nxt      = r_score_a;
    w_score_b_nxt      = r_score_b;
    w_score_c_nxt      = r_score_c;
    w_rcnt_nxt         = r_rcnt;
    w_round_rst_nxt    = 1'b0;
    w_match_done_nxt   = r_match_done;
    w_match_winner_nxt = r_match_winner;

    // NEW_MATCH parks in HOLD so a result still on the bus is never scored
    if (NEW_MATCH) begin
      w_score_a_nxt      = '0;
      w_score_b_nxt      = '0;
      w_score_c_nxt      = '0;
      w_rcnt_nxt         = '0;
      w_match_done_nxt   = 1'b0;
      w_match_winner_nxt = 3'b000;
      w_round_rst_nxt    = 1'b1;
      w_state_nxt        = HOLD;
    end else begin
      case (r_state)
        WAIT: begin
          if (w_is_result) begin
            w_score_a_nxt   = sat_score(r_score_a, w_award[P_A]);
            w_score_b_nxt   = sat_score(r_score_b, w_award[P_B]);
            w_score_c_nxt   = sat_score(r_score_c, w_award[P_C]);
            w_rcnt_nxt      = sat_rcnt(r_rcnt);
            w_round_rst_nxt = 1'b1;
            w_state_nxt     = HOLD;
          end
        end
        HOLD: begin
          if (!w_is_result) begin
            if (|w_hit) begin
              w_state_nxt        = DONE;
              w_match_done_nxt   = 1'b1;
              w_match_winner_nxt = w_hit;
            end else begin
              w_state_nxt = WAIT;
            end
          end
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state        <= WAIT;
      r_score_a      <= '0;
      r_score_b      <= '0;
      r_score_c      <= '0;
      r_rcnt         <= '0;
      r_round_rst    <= 1'b0;
      r_match_done   <= 1'b0;
      r_match_winner <= 3'b000;
    end else begin
      r_state        <= w_state_nxt;
      r_score_a      <= w_score_a_nxt;
      r_score_b      <= w_score_b_nxt;
      r_score_c      <= w_score_c_nxt;
      r_rcnt         <= w_rcnt_nxt;
      r_round_rst    <= w_round_rst_nxt;
      r_match_done   <= w_match_done_nxt;
      r_match_winner <= w_match_winner_nxt;
    end
  end

  assign ROUND_RST    = r_round_rst;
  assign SCORE_A      = r_score_a;
  assign SCORE_B      = r_score_b;
  assign SCORE_C      = r_score_c;
  assign ROUND_CNT    = r_rcnt;
  assign MATCH_DONE   = r_match_done;
  assign MATCH_WINNER = r_match_winner;

endmodule
